// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bundle: hazard sources from ID/EX/MEM in, per-latch stall/invalidate strobes out.
// Optional statistics outputs appear only when HAZARD_STATS_EN is defined.
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int STAT_WIDTH     = 16
);
   logic [REG_ADDR_WIDTH-1:0] id_rs;
   logic [REG_ADDR_WIDTH-1:0] id_rt;
   logic                      id_uses_rs;
   logic                      id_uses_rt;
   logic [REG_ADDR_WIDTH-1:0] ex_rd;
   logic                      ex_is_load;
   logic                      ex_branch_taken;
   logic                      mem_req;
   logic                      mem_done;

   logic pc_stall;
   logic stall_ifid, stall_idex, stall_exmem, stall_memwb;
   logic inv_ifid, inv_idex, inv_exmem, inv_memwb;
   logic mem_err;
`ifdef HAZARD_STATS_EN
   logic [STAT_WIDTH-1:0] stat_stall_cycles;
   logic [STAT_WIDTH-1:0] stat_flushes;
`endif

   // master = pipeline datapath side, slave = hazard controller
   modport master (
`ifdef HAZARD_STATS_EN
      input  stat_stall_cycles, stat_flushes,
`endif
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_is_load,
      output ex_branch_taken, mem_req, mem_done,
      input  pc_stall, stall_ifid, stall_idex, stall_exmem, stall_memwb,
      input  inv_ifid, inv_idex, inv_exmem, inv_memwb, mem_err
   );

   modport slave (
`ifdef HAZARD_STATS_EN
      output stat_stall_cycles, stat_flushes,
`endif
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_is_load,
      input  ex_branch_taken, mem_req, mem_done,
      output pc_stall, stall_ifid, stall_idex, stall_exmem, stall_memwb,
      output inv_ifid, inv_idex, inv_exmem, inv_memwb, mem_err
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: Mealy stall/invalidate strobes (0-cycle latency) for load-use, taken branch, memory wait,
// plus post-reset flush and memory-wait timeout. HAZARD_STATS_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int FLUSH_CYCLES   = 4,
   parameter int MEM_TIMEOUT    = 64
`ifdef HAZARD_STATS_EN
   ,parameter int STAT_WIDTH    = 16
`endif
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave hz
);
   localparam logic [1:0] FLUSH    = 2'd0;
   localparam logic [1:0] RUN      = 2'd1;
   localparam logic [1:0] MEM_WAIT = 2'd2;
   localparam int WW = $clog2(MEM_TIMEOUT) + 1;

   logic [1:0]    state, state_nx;
   logic [3:0]    flush_cnt, flush_cnt_nx;
   logic [WW-1:0] wait_cnt, wait_cnt_nx;
   logic          err_q;

   logic [REG_ADDR_WIDTH-1:0] id_rs, id_rt, ex_rd;
   logic flush_all, hold, branch_kill, load_use_stall, timeout;
   logic mem_wait, load_use;

   assign id_rs = hz.id_rs;
   assign id_rt = hz.id_rt;
   assign ex_rd = hz.ex_rd;

   assign mem_wait = hz.mem_req & ~hz.mem_done;
   assign load_use = hz.ex_is_load && (ex_rd != '0) &&
                     ((hz.id_uses_rs && (id_rs == ex_rd)) || (hz.id_uses_rt && (id_rt == ex_rd)));

   always_comb begin
      state_nx       = state;
      flush_cnt_nx   = flush_cnt;
      wait_cnt_nx    = wait_cnt;
      flush_all      = 1'b0;
      hold           = 1'b0;
      branch_kill    = 1'b0;
      load_use_stall = 1'b0;
      timeout        = 1'b0;
      case (state)
         FLUSH: begin
            flush_all = 1'b1;
            if (flush_cnt == 4'(FLUSH_CYCLES - 1)) begin
               state_nx = RUN;
            end else begin
               flush_cnt_nx = flush_cnt + 4'd1;
            end
         end
         RUN: begin
            // wrong-path ID instruction makes the branch outrank load-use
            if (mem_wait) begin
               hold        = 1'b1;
               state_nx    = MEM_WAIT;
               wait_cnt_nx = WW'(1);
            end else if (hz.ex_branch_taken) begin
               branch_kill = 1'b1;
            end else if (load_use) begin
               load_use_stall = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (hz.mem_done) begin
               state_nx = RUN;
            end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
               timeout  = 1'b1;
               state_nx = RUN;
            end else begin
               hold        = 1'b1;
               wait_cnt_nx = wait_cnt + WW'(1);
            end
         end
         default: state_nx = FLUSH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FLUSH;
         flush_cnt <= '0;
         wait_cnt  <= '0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nx;
         flush_cnt <= flush_cnt_nx;
         wait_cnt  <= wait_cnt_nx;
         if (timeout) err_q <= 1'b1;
      end
   end

   // Invalidate and stall are disjoint per latch by construction of the cases above
   assign hz.pc_stall    = ~rst & (flush_all | hold | load_use_stall);
   assign hz.stall_ifid  = ~rst & (hold | load_use_stall);
   assign hz.stall_idex  = ~rst & hold;
   assign hz.stall_exmem = ~rst & hold;
   assign hz.stall_memwb = 1'b0;
   assign hz.inv_ifid    = ~rst & (flush_all | branch_kill);
   assign hz.inv_idex    = ~rst & (flush_all | branch_kill | load_use_stall);
   assign hz.inv_exmem   = ~rst & flush_all;
   assign hz.inv_memwb   = ~rst & (flush_all | hold);
   assign hz.mem_err     = ~rst & (err_q | timeout);

`ifdef HAZARD_STATS_EN
   logic [STAT_WIDTH-1:0] stall_cnt, flush_evt_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt     <= '0;
         flush_evt_cnt <= '0;
      end else begin
         if ((hold | load_use_stall) && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         if (branch_kill && !(&flush_evt_cnt)) flush_evt_cnt <= flush_evt_cnt + 1'b1;
      end
   end

   assign hz.stat_stall_cycles = stall_cnt;
   assign hz.stat_flushes      = flush_evt_cnt;
`endif
endmodule
